// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: write-port indices and
// a helper for locating a port's slice inside a flattened port vector.
package regfile_pkg;

    localparam int WP_ALU  = 0;
    localparam int WP_LOAD = 1;
    localparam int NUM_WP  = 2;

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads plus a registered population count.
// A load issue (set) beats a load writeback (clear) to the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    output logic [DEPTH-1:0]  busy_o,
    output logic [CNT_W-1:0]  busy_count_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             set_ok;
    logic             inc;
    logic             dec;

    assign set_ok = set_i && !((ZERO_REG != 0) && (set_addr_i == '0));

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        inc     = 1'b0;
        dec     = 1'b0;
        if (en_i) begin
            // Count moves only on real transitions so it always equals the population.
            inc = set_ok && !busy_q[set_addr_i];
            dec = clr_i && busy_q[clr_addr_i] && !(set_ok && (set_addr_i == clr_addr_i));
            if (clr_i) begin
                busy_d[clr_addr_i] = 1'b0;
            end
            if (set_ok) begin
                busy_d[set_addr_i] = 1'b1;
            end
            count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with ALU and load write ports, write-to-read bypass
// and a load scoreboard whose busy flags are forwarded to every read port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_enable,
    input  logic [NUM_READ*ADDR_W-1:0]   r_address,
    output logic [NUM_READ*WIDTH-1:0]    r_data,
    output logic [NUM_READ-1:0]          r_busy,
    input  logic                         w_enable0,
    input  logic [ADDR_W-1:0]            w_address0,
    input  logic [WIDTH-1:0]             w_data0,
    input  logic                         w_enable1,
    input  logic [ADDR_W-1:0]            w_address1,
    input  logic [WIDTH-1:0]             w_data1,
    input  logic                         sb_set,
    input  logic [ADDR_W-1:0]            sb_address,
    output logic [$clog2(DEPTH+1)-1:0]   busy_count
);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              we [NUM_WP];
    logic [ADDR_W-1:0] wa [NUM_WP];
    logic [WIDTH-1:0]  wd [NUM_WP];
    logic              bypass_ok;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        we[WP_ALU]  = w_enable0;
        wa[WP_ALU]  = w_address0;
        wd[WP_ALU]  = w_data0;
        we[WP_LOAD] = w_enable1;
        wa[WP_LOAD] = w_address1;
        wd[WP_LOAD] = w_data1;
    end

    assign bypass_ok = (BYPASS != 0) && clk_enable && rst_n;

    // The load port is applied first so the ALU port (younger instruction) wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (clk_enable) begin
            if (we[WP_LOAD] && !is_zero_reg(wa[WP_LOAD])) begin
                regs_q[wa[WP_LOAD]] <= wd[WP_LOAD];
            end
            if (we[WP_ALU] && !is_zero_reg(wa[WP_ALU])) begin
                regs_q[wa[WP_ALU]] <= wd[WP_ALU];
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W),
        .CNT_W    ($clog2(DEPTH + 1))
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (clk_enable),
        .set_i        (sb_set),
        .set_addr_i   (sb_address),
        .clr_i        (w_enable1),
        .clr_addr_i   (w_address1),
        .busy_o       (busy),
        .busy_count_o (busy_count)
    );

    always_comb begin
        r_data  = '0;
        r_busy  = '0;
        rd_addr = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_addr = r_address[slice_lo(i, ADDR_W) +: ADDR_W];
            if (is_zero_reg(rd_addr)) begin
                r_data[slice_lo(i, WIDTH) +: WIDTH] = '0;
            end else if (bypass_ok && we[WP_ALU] && (wa[WP_ALU] == rd_addr)) begin
                r_data[slice_lo(i, WIDTH) +: WIDTH] = wd[WP_ALU];
            end else if (bypass_ok && we[WP_LOAD] && (wa[WP_LOAD] == rd_addr)) begin
                r_data[slice_lo(i, WIDTH) +: WIDTH] = wd[WP_LOAD];
            end else begin
                r_data[slice_lo(i, WIDTH) +: WIDTH] = regs_q[rd_addr];
            end

            // A load landing this cycle makes its register ready for decode immediately.
            if (is_zero_reg(rd_addr)) begin
                r_busy[i] = 1'b0;
            end else if (bypass_ok && we[WP_LOAD] && (wa[WP_LOAD] == rd_addr)) begin
                r_busy[i] = 1'b0;
            end else begin
                r_busy[i] = busy[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table on the default 32x32 two-read
// configuration, plus a randomised run on a 16x16 four-read instance.
module tb_regfile_sb;

    localparam int AW  = 5;
    localparam int W   = 32;
    localparam int NR  = 2;
    localparam int CW  = 6;
    localparam int BAW = 4;
    localparam int BW  = 16;
    localparam int BNR = 4;
    localparam int BD  = 16;
    localparam int BCW = 5;

    logic clk;
    logic rst_n;
    logic clk_enable;

    logic [NR*AW-1:0] a_raddr;
    logic [NR*W-1:0]  a_rdata;
    logic [NR-1:0]    a_rbusy;
    logic             a_we0, a_we1, a_sbs;
    logic [AW-1:0]    a_wa0, a_wa1, a_sba;
    logic [W-1:0]     a_wd0, a_wd1;
    logic [CW-1:0]    a_cnt;

    logic [BNR*BAW-1:0] b_raddr;
    logic [BNR*BW-1:0]  b_rdata;
    logic [BNR-1:0]     b_rbusy;
    logic               b_we0, b_we1, b_sbs;
    logic [BAW-1:0]     b_wa0, b_wa1, b_sba;
    logic [BW-1:0]      b_wd0, b_wd1;
    logic [BCW-1:0]     b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .r_address  (a_raddr),
        .r_data     (a_rdata),
        .r_busy     (a_rbusy),
        .w_enable0  (a_we0),
        .w_address0 (a_wa0),
        .w_data0    (a_wd0),
        .w_enable1  (a_we1),
        .w_address1 (a_wa1),
        .w_data1    (a_wd1),
        .sb_set     (a_sbs),
        .sb_address (a_sba),
        .busy_count (a_cnt)
    );

    regfile_sb #(
        .WIDTH    (BW),
        .DEPTH    (BD),
        .NUM_READ (BNR)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .r_address  (b_raddr),
        .r_data     (b_rdata),
        .r_busy     (b_rbusy),
        .w_enable0  (b_we0),
        .w_address0 (b_wa0),
        .w_data0    (b_wd0),
        .w_enable1  (b_we1),
        .w_address1 (b_wa1),
        .w_data1    (b_wd1),
        .sb_set     (b_sbs),
        .sb_address (b_sba),
        .busy_count (b_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          ce;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [W-1:0]  wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [W-1:0]  wd1;
        logic          sbs;
        logic [AW-1:0] sba;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [W-1:0]  erd0;
        logic [W-1:0]  erd1;
        logic          eb0;
        logic          eb1;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic ce,
                           input logic we0, input int wa0, input logic [W-1:0] wd0,
                           input logic we1, input int wa1, input logic [W-1:0] wd1,
                           input logic sbs, input int sba, input int ra0, input int ra1,
                           input logic [W-1:0] erd0, input logic [W-1:0] erd1,
                           input logic eb0, input logic eb1, input int ecnt);
        vec_t v;
        v.rst = rst; v.ce = ce;
        v.we0 = we0; v.wa0 = AW'(wa0); v.wd0 = wd0;
        v.we1 = we1; v.wa1 = AW'(wa1); v.wd1 = wd1;
        v.sbs = sbs; v.sba = AW'(sba);
        v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
        v.erd0 = erd0; v.erd1 = erd1;
        v.eb0 = eb0; v.eb1 = eb1; v.ecnt = CW'(ecnt);
        vq.push_back(v);
    endtask

    // Driver tasks
    task automatic drive_a(input vec_t v);
        rst_n      = v.rst;
        clk_enable = v.ce;
        a_we0 = v.we0; a_wa0 = v.wa0; a_wd0 = v.wd0;
        a_we1 = v.we1; a_wa1 = v.wa1; a_wd1 = v.wd1;
        a_sbs = v.sbs; a_sba = v.sba;
        a_raddr = {v.ra1, v.ra0};
    endtask

    task automatic idle_b();
        b_we0 = 1'b0; b_wa0 = '0; b_wd0 = '0;
        b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
        b_sbs = 1'b0; b_sba = '0; b_raddr = '0;
    endtask

    // Reference state for the four-read instance
    logic [BW-1:0] m_mem [BD];
    logic [BD-1:0] m_busy;

    initial begin
        vec_t v;
        logic [BAW-1:0] ra;
        logic [BW-1:0]  exp_d;
        logic           exp_b;
        int             pop;

        rst_n = 1'b0;
        clk_enable = 1'b1;
        a_we0 = 1'b0; a_wa0 = '0; a_wd0 = '0;
        a_we1 = 1'b0; a_wa1 = '0; a_wd1 = '0;
        a_sbs = 1'b0; a_sba = '0; a_raddr = '0;
        idle_b();

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Post-reset sweep of every address
        check("reset_cnt_a", 64'(a_cnt), 64'd0);
        check("reset_cnt_b", 64'(b_cnt), 64'd0);
        for (int a = 0; a < 32; a += 2) begin
            a_raddr = {AW'(a + 1), AW'(a)};
            #1;
            check($sformatf("reset_rd r%0d", a), 64'(a_rdata[0 +: W]), 64'd0);
            check($sformatf("reset_rd r%0d", a + 1), 64'(a_rdata[W +: W]), 64'd0);
            check($sformatf("reset_busy r%0d/r%0d", a, a + 1), 64'(a_rbusy), 64'd0);
        end

        //      rst ce we0 wa0 wd0           we1 wa1 wd1       sbs sba ra0 ra1 erd0          erd1          eb0 eb1 cnt
        add_vec(0, 1, 1, 5,  32'h1234,      1, 6,  32'h9,    1, 7,  5,  6,  32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  5,  6,  32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 1, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,    0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        add_vec(1, 1, 1, 7,  32'h1111,      1, 7,  32'h2222, 0, 0,  7,  1,  32'h1111,     32'h0,        0, 0, 0);
        add_vec(1, 1, 1, 0,  32'hFFFF,      0, 0,  32'h0,    0, 0,  7,  0,  32'h1111,     32'h0,        0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  0,  7,  32'h0,        32'h1111,     0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 9,  9,  3,  32'h0,        32'h0,        0, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  9,  9,  32'h0,        32'h0,        1, 1, 1);
        add_vec(1, 1, 0, 0,  32'h0,         1, 9,  32'hABCD, 0, 0,  9,  9,  32'hABCD,     32'hABCD,     0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         1, 3,  32'h3333, 1, 3,  3,  9,  32'h3333,     32'hABCD,     0, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  3,  9,  32'h3333,     32'hABCD,     1, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         1, 3,  32'h4444, 1, 3,  1,  9,  32'h0,        32'hABCD,     0, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  3,  1,  32'h4444,     32'h0,        1, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         1, 3,  32'h5555, 1, 10, 3,  10, 32'h5555,     32'h0,        0, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  3,  10, 32'h5555,     32'h0,        0, 1, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0,  0,  10, 32'h0,        32'h0,        0, 1, 1);
        add_vec(1, 0, 1, 4,  32'h55,        1, 10, 32'h77,   1, 4,  4,  10, 32'h0,        32'h0,        0, 1, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  4,  10, 32'h0,        32'h0,        0, 1, 1);
        add_vec(0, 0, 1, 5,  32'h99,        0, 0,  32'h0,    0, 0,  5,  3,  32'hDEADBEEF, 32'h5555,     0, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  5,  10, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 1, 1, 12, 32'hA,         0, 0,  32'h0,    1, 12, 12, 13, 32'hA,        32'h0,        0, 0, 1);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  12, 12, 32'hA,        32'hA,        1, 1, 1);
        add_vec(1, 1, 0, 0,  32'h0,         1, 13, 32'hB,    0, 0,  13, 12, 32'hB,        32'hA,        0, 1, 1);
        add_vec(0, 1, 1, 12, 32'h77,        1, 13, 32'h88,   0, 0,  12, 13, 32'hA,        32'hB,        1, 0, 0);
        add_vec(1, 1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  12, 13, 32'h0,        32'h0,        0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive_a(v);
            @(negedge clk);
            check($sformatf("v%0d rd0", i), 64'(a_rdata[0 +: W]), 64'(v.erd0));
            check($sformatf("v%0d rd1", i), 64'(a_rdata[W +: W]), 64'(v.erd1));
            check($sformatf("v%0d busy0", i), 64'(a_rbusy[0]), 64'(v.eb0));
            check($sformatf("v%0d busy1", i), 64'(a_rbusy[1]), 64'(v.eb1));
            @(posedge clk);
            #1;
            check($sformatf("v%0d busy_count", i), 64'(a_cnt), 64'(v.ecnt));
        end

        // Randomised run on the four-read instance against a reference model
        a_we0 = 1'b0; a_we1 = 1'b0; a_sbs = 1'b0;
        rst_n = 1'b0;
        clk_enable = 1'b1;
        idle_b();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < BD; r++) m_mem[r] = '0;
        m_busy = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            clk_enable = ($urandom_range(0, 7) != 0);
            b_we0 = 1'($urandom_range(0, 1));
            b_wa0 = BAW'($urandom_range(0, BD - 1));
            b_wd0 = BW'($urandom_range(0, 16'hFFFF));
            b_we1 = 1'($urandom_range(0, 1));
            b_wa1 = BAW'($urandom_range(0, BD - 1));
            b_wd1 = BW'($urandom_range(0, 16'hFFFF));
            b_sbs = ($urandom_range(0, 2) == 0);
            b_sba = BAW'($urandom_range(0, BD - 1));
            if (b_sbs && b_we1 && (b_sba == b_wa1)) b_sbs = 1'b0;
            for (int p = 0; p < BNR; p++) begin
                case ($urandom_range(0, 3))
                    0:       b_raddr[p*BAW +: BAW] = b_wa0;
                    1:       b_raddr[p*BAW +: BAW] = b_wa1;
                    default: b_raddr[p*BAW +: BAW] = BAW'($urandom_range(0, BD - 1));
                endcase
            end

            @(negedge clk);
            for (int p = 0; p < BNR; p++) begin
                ra = b_raddr[p*BAW +: BAW];
                if (ra == 0) exp_d = '0;
                else if (clk_enable && b_we0 && b_wa0 == ra) exp_d = b_wd0;
                else if (clk_enable && b_we1 && b_wa1 == ra) exp_d = b_wd1;
                else exp_d = m_mem[ra];
                if (ra == 0) exp_b = 1'b0;
                else if (clk_enable && b_we1 && b_wa1 == ra) exp_b = 1'b0;
                else exp_b = m_busy[ra];
                check($sformatf("rand c%0d p%0d rd r%0d", cyc, p, ra), 64'(b_rdata[p*BW +: BW]), 64'(exp_d));
                check($sformatf("rand c%0d p%0d busy r%0d", cyc, p, ra), 64'(b_rbusy[p]), 64'(exp_b));
            end

            if (clk_enable) begin
                if (b_we1 && b_wa1 != 0) m_mem[b_wa1] = b_wd1;
                if (b_we0 && b_wa0 != 0) m_mem[b_wa0] = b_wd0;
                if (b_we1) m_busy[b_wa1] = 1'b0;
                if (b_sbs && b_sba != 0) m_busy[b_sba] = 1'b1;
            end
            pop = 0;
            for (int r = 0; r < BD; r++) pop += int'(m_busy[r]);

            @(posedge clk);
            #1;
            check($sformatf("rand c%0d busy_count", cyc), 64'(b_cnt), 64'(pop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Generalised in data width, register count and number of read ports. Adds a second write port, write-to-read bypass, and a per-register busy scoreboard for outstanding loads.
- Sits in the decode/writeback path of the CPU pipeline:
  - Decode reads operands and busy flags.
  - Write port 0 takes ALU writeback; write port 1 takes load writeback.
  - The issue logic sets scoreboard bits for loads in flight.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width (derived; do not override).
- NUM_READ, 2, number of read ports; at least 1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- clk_enable  in  1  global advance enable; state updates only when high (reset excepted).
- r_address  in  NUM_READ*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- r_data  out  NUM_READ*WIDTH  read data, combinational; port i at bits [i*WIDTH +: WIDTH].
- r_busy  out  NUM_READ  per read port, register has a load outstanding (combinational).
- w_enable0  in  1  write port 0 (ALU) enable.
- w_address0  in  ADDR_W  write port 0 address.
- w_data0  in  WIDTH  write port 0 data.
- w_enable1  in  1  write port 1 (load) enable; also clears the busy bit.
- w_address1  in  ADDR_W  write port 1 address.
- w_data1  in  WIDTH  write port 1 data.
- sb_set  in  1  mark register sb_address busy (load issued).
- sb_address  in  ADDR_W  scoreboard set address.
- busy_count  out  $clog2(DEPTH+1)  registered count of busy registers.

Behaviour:
- Reset (rst_n=0 at a rising edge, regardless of clk_enable):
  - All registers, all busy bits and busy_count go to 0.
  - Writes and sb_set presented in that cycle are dropped.
  - After reset, every r_data reads 0 and every r_busy reads 0.
- Writes: on a rising edge with rst_n=1 and clk_enable=1:
  - Port k with w_enablek=1 stores w_datak; write latency is 1 cycle.
  - Writes to register 0 are ignored when ZERO_REG=1.
  - Both ports targeting the same address: port 0 wins (port 0 carries the younger instruction).
- Reads are asynchronous. r_data for port i is resolved in this order:
  - ZERO_REG=1 and address 0 -> 0.
  - Otherwise, if BYPASS=1, clk_enable=1 and w_enable0 matches the address -> w_data0.
  - Otherwise, if BYPASS=1, clk_enable=1 and w_enable1 matches the address -> w_data1.
  - Otherwise -> stored value.
  - Bypass is never taken while rst_n=0.
- Scoreboard (busy[DEPTH]), on an enabled edge:
  - sb_set=1 sets busy[sb_address].
  - w_enable1=1 clears busy[w_address1].
  - Set and clear on the same address in the same cycle: set wins (new load issued).
  - w_enable0 does not touch busy bits.
  - With ZERO_REG=1, busy[0] stays 0.
- r_busy[i] = busy[r_address_i], except:
  - BYPASS=1 with a same-cycle w_enable1 clear of that address (and clk_enable=1) -> 0.
  - ZERO_REG=1 and address 0 -> 0.
- busy_count: registered; equals the population of busy after each edge.
  - Update rule: +1 on a set of a not-busy register, -1 on an effective clear of a busy register.
  - Both in one cycle on different addresses: net 0.
  - Never wraps; saturation is impossible by construction.
- clk_enable=0: no state changes, no bypass, reads return stored values.

Decomposition:
- Shared package regfile_pkg holds:
  - Localparams for write-port indices (WP_ALU=0, WP_LOAD=1).
  - An index helper for slicing flattened port vectors.
- One natural sub-module: regfile_scoreboard.
  - Contents: busy bits, busy_count, and the set/clear priority logic.
  - Its outputs feed the r_busy forwarding muxes in the top level.
- Storage and bypass muxes live in the top level.

Test Plan:
- Reset then read all addresses -> every r_data=0, every r_busy=0, busy_count=0.
- Write 0xDEADBEEF to r5 via port 0 while reading r5 in the same cycle -> r_data=0xDEADBEEF that cycle (BYPASS=1); stored value 0xDEADBEEF on the next cycle.
- Both ports write r7 in one cycle (port 0 0x1111, port 1 0x2222) -> r7=0x1111. Write r0=0xFFFF -> r0 reads 0.
- Sequence for r9 and r3:
  - sb_set r9 -> r_busy=1, busy_count=1.
  - Next cycle: w_enable1 to r9 with 0xABCD while reading r9 -> r_busy=0 and r_data=0xABCD that cycle; busy_count=0 afterwards.
  - Same-cycle sb_set r3 plus w_enable1 r3 -> r3 stays busy.
- clk_enable=0 with w_enable0 r4=0x55 and sb_set r4 -> r4 unchanged, not busy, no bypass. Assert rst_n=0 with clk_enable=0 -> state cleared.
- Configuration NUM_READ=4, DEPTH=16, WIDTH=16: random writes checked on all four ports against a reference model.
